wb_arbiter: RTL

Writeback arbiter between functional-unit (FU) result outputs and the physical register file write ports. Accepts up to FU_NUM results per cycle through a valid/ready handshake, holds each in a one-entry per-FU buffer, and round-robin grants up to WBPORT_NUM of them per cycle onto registered write-enable/index/data outputs. These outputs connect directly to the regfile write ports, which also set the ready bits. Results targeting physical register 0 are discarded when HAS_ZERO is set.

---
 rtl/wb_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry holding buffer per functional unit, round-robin
// granted onto registered regfile write ports.
module wb_arbiter #(
    parameter  int unsigned FU_NUM     = 8,
    parameter  int unsigned WBPORT_NUM = 6,
    parameter  int unsigned SIZE       = 80,
    parameter  int unsigned DATA_W     = 64,
    parameter  int unsigned HAS_ZERO   = 1,
    localparam int unsigned IDX_W      = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FU_NUM-1:0]     i_fu_vld,
    input  logic [IDX_W-1:0]      i_fu_idx     [FU_NUM],
    input  logic [DATA_W-1:0]     i_fu_data    [FU_NUM],
    output logic [FU_NUM-1:0]     o_fu_rdy,
    output logic [WBPORT_NUM-1:0] o_write_en,
    output logic [IDX_W-1:0]      o_write_idx  [WBPORT_NUM],
    output logic [DATA_W-1:0]     o_write_data [WBPORT_NUM],
    output logic [31:0]           o_conflict_cnt
);
    localparam int unsigned PTR_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
    localparam int unsigned SCAN_W = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(FU_NUM + 1);

    logic [FU_NUM-1:0]     r_hold_vld;
    logic [IDX_W-1:0]      r_hold_idx  [FU_NUM];
    logic [DATA_W-1:0]     r_hold_data [FU_NUM];
    logic [PTR_W-1:0]      r_rr_ptr;

    logic [FU_NUM-1:0]     w_grant;
    logic [FU_NUM-1:0]     w_drop;
    logic [WBPORT_NUM-1:0] w_port_en;
    logic [PTR_W-1:0]      w_port_sel [WBPORT_NUM];
    logic [CNT_W-1:0]      w_nreq;
    logic [CNT_W-1:0]      w_ngnt;
    logic [PTR_W-1:0]      w_last;
    logic [PTR_W-1:0]      w_rr_nxt;
    logic [SCAN_W-1:0]     w_scan;
    logic [PTR_W-1:0]      w_k;

    // Scan held entries from rr_ptr, packing valid ones onto ports 0,1,...
    always_comb begin
        w_grant   = '0;
        w_drop    = '0;
        w_port_en = '0;
        for (int j = 0; j < WBPORT_NUM; j++) w_port_sel[j] = '0;
        w_nreq = '0;
        w_ngnt = '0;
        w_last = r_rr_ptr;
        w_scan = '0;
        w_k    = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            w_scan = {1'b0, r_rr_ptr} + SCAN_W'(i);
            if (w_scan >= SCAN_W'(FU_NUM)) w_scan = w_scan - SCAN_W'(FU_NUM);
            w_k = w_scan[PTR_W-1:0];
            if (r_hold_vld[w_k]) begin
                if ((HAS_ZERO != 0) && (r_hold_idx[w_k] == '0)) begin
                    w_drop[w_k] = 1'b1;
                end else begin
                    w_nreq = w_nreq + CNT_W'(1);
                    if (w_ngnt < CNT_W'(WBPORT_NUM)) begin
                        w_grant[w_k] = 1'b1;
                        for (int j = 0; j < WBPORT_NUM; j++) begin
                            if (w_ngnt == CNT_W'(j)) begin
                                w_port_en[j]  = 1'b1;
                                w_port_sel[j] = w_k;
                            end
                        end
                        w_ngnt = w_ngnt + CNT_W'(1);
                        w_last = w_k;
                    end
                end
            end
        end
    end

    assign w_rr_nxt = (w_last == PTR_W'(FU_NUM - 1)) ? '0 : w_last + PTR_W'(1);

    // Ready depends only on registered state, so no vld->rdy path exists.
    assign o_fu_rdy = ~r_hold_vld | w_grant | w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_vld     <= '0;
            r_rr_ptr       <= '0;
            o_write_en     <= '0;
            o_conflict_cnt <= '0;
            for (int j = 0; j < WBPORT_NUM; j++) begin
                o_write_idx[j]  <= '0;
                o_write_data[j] <= '0;
            end
        end else begin
            for (int k = 0; k < FU_NUM; k++) begin
                if (i_fu_vld[k] && o_fu_rdy[k]) r_hold_vld[k] <= 1'b1;
                else if (w_grant[k] || w_drop[k]) r_hold_vld[k] <= 1'b0;
            end
            o_write_en <= w_port_en;
            for (int j = 0; j < WBPORT_NUM; j++) begin
                if (w_port_en[j]) begin
                    o_write_idx[j]  <= r_hold_idx[w_port_sel[j]];
                    o_write_data[j] <= r_hold_data[w_port_sel[j]];
                end
            end
            if (w_ngnt != '0) r_rr_ptr <= w_rr_nxt;
            if ((w_nreq > CNT_W'(WBPORT_NUM)) && (o_conflict_cnt != 32'hFFFF_FFFF))
                o_conflict_cnt <= o_conflict_cnt + 32'd1;
        end
    end

    // Payload registers are qualified by r_hold_vld and need no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FU_NUM; k++) begin
            if (i_fu_vld[k] && o_fu_rdy[k]) begin
                r_hold_idx[k]  <= i_fu_idx[k];
                r_hold_data[k] <= i_fu_data[k];
            end
        end
    end

    // Two live write ports must never target the same physical register.
    always @(posedge clk) begin
        if (!rst) begin
            for (int a = 0; a < WBPORT_NUM; a++) begin
                for (int b = a + 1; b < WBPORT_NUM; b++) begin
                    if (o_write_en[a] && o_write_en[b])
                        assert (o_write_idx[a] != o_write_idx[b]);
                end
            end
        end
    end
endmodule
